// File: rtl/i2c_write_controller.sv
// I2C single-byte write master: START, address+W, ACK, data byte, ACK, STOP.
// Latency: 80*CLK_DIV clk from accepted start to done (44*CLK_DIV when the address is NACKed).
// Backpressure: none; start is sampled only in IDLE and ignored while busy.
module i2c_write_controller #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic [7:0] data,
    output logic       busy,
    output logic       done,
    output logic       ack_error,
    output logic       i2c_scl,
    inout  wire        i2c_sda
);
    typedef enum logic [2:0] {IDLE, START, ADDR, ACK1, DATA, ACK2, STOP, DONE} state_t;

    localparam logic [7:0] Q_LAST = 8'(CLK_DIV - 1);

    state_t     state, state_n;
    logic [7:0] q_cnt;
    logic [1:0] qtr;
    logic [2:0] bit_cnt;
    logic [7:0] addr_byte;
    logic [7:0] data_q;
    logic       ack_smp;
    logic       sda_low;
    logic       tick;
    logic       slot_end;
    logic       sample_pt;

    assign busy      = (state != IDLE) && (state != DONE);
    assign done      = (state == DONE);
    assign tick      = busy && (q_cnt == Q_LAST);
    assign slot_end  = tick && (qtr == 2'd3);
    assign sample_pt = tick && (qtr == 2'd2) && ((state == ACK1) || (state == ACK2));
    assign i2c_sda   = sda_low ? 1'b0 : 1'bz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        i2c_scl = 1'b1;
        sda_low = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_n = START;
            end
            START: begin
                sda_low = qtr[1];
                if (slot_end) state_n = ADDR;
            end
            ADDR: begin
                i2c_scl = qtr[1];
                sda_low = ~addr_byte[bit_cnt];
                if (slot_end && (bit_cnt == 3'd0)) state_n = ACK1;
            end
            ACK1: begin
                i2c_scl = qtr[1];
                if (slot_end) state_n = ack_smp ? STOP : DATA;
            end
            DATA: begin
                i2c_scl = qtr[1];
                sda_low = ~data_q[bit_cnt];
                if (slot_end && (bit_cnt == 3'd0)) state_n = ACK2;
            end
            ACK2: begin
                i2c_scl = qtr[1];
                if (slot_end) state_n = STOP;
            end
            STOP: begin
                // SCL rises one tick before SDA is released, giving the stop condition
                i2c_scl = (qtr != 2'd0);
                sda_low = ~qtr[1];
                if (slot_end) state_n = DONE;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_cnt     <= '0;
            qtr       <= '0;
            bit_cnt   <= '0;
            addr_byte <= '0;
            data_q    <= '0;
            ack_smp   <= 1'b0;
            ack_error <= 1'b0;
        end else begin
            if (busy) begin
                q_cnt <= tick ? 8'd0 : q_cnt + 8'd1;
                if (tick) qtr <= qtr + 2'd1;
            end else begin
                q_cnt <= '0;
                qtr   <= '0;
            end
            if ((state == IDLE) && start) begin
                addr_byte <= {addr, 1'b0};
                data_q    <= data;
                bit_cnt   <= 3'd7;
                ack_error <= 1'b0;
            end
            // wraps 0 -> 7 at the end of the address byte, ready for the data byte
            if (slot_end && ((state == ADDR) || (state == DATA))) begin
                bit_cnt <= bit_cnt - 3'd1;
            end
            if (sample_pt) begin
                ack_smp <= i2c_sda;
                if (i2c_sda) ack_error <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_i2c_write_controller.sv
// Bench for i2c_write_controller: table vectors, random transactions, abort and held-start
// sequences, with a bus monitor/responder that decodes the SDA/SCL waveform.
module tb_i2c_write_controller;
    localparam int CD = 4;

    typedef struct {
        logic [6:0] addr;
        logic [7:0] data;
        bit         aa;
        bit         ad;
        bit         intf;
        int         exp_err;
        int         exp_nbits;
        int         exp_lat;
    } tvec_t;

    typedef struct {
        int n;
        int word;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [6:0] addr = '0;
    logic [7:0] data = '0;
    logic       busy, done, ack_error, i2c_scl;
    wire        i2c_sda;
    logic       slave_low = 1'b0;
    bit         rsp_ack_addr = 1'b1;
    bit         rsp_ack_data = 1'b1;

    assign i2c_sda = slave_low ? 1'b0 : 1'bz;
    pullup (i2c_sda);

    i2c_write_controller #(.CLK_DIV(CD)) dut (
        .clk(clk), .rst(rst), .start(start), .addr(addr), .data(data),
        .busy(busy), .done(done), .ack_error(ack_error),
        .i2c_scl(i2c_scl), .i2c_sda(i2c_sda)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int rd_idx = 0;

    // bus monitor and responder, sampled on the falling clk edge
    rec_t mon_q[$];
    int   n_start = 0, n_stop = 0, n_done = 0;
    int   falls = 0, bit_n = 0, word = 0;
    bit   in_txn = 1'b0;
    logic prev_scl = 1'b1, prev_sda = 1'b1, scl_now, sda_now;

    always @(negedge clk) begin
        if (rst) begin
            slave_low = 1'b0;
            in_txn    = 1'b0;
            prev_scl  = 1'b1;
            prev_sda  = 1'b1;
        end else begin
            scl_now = i2c_scl;
            sda_now = i2c_sda;
            if (done) n_done++;
            if (prev_scl && scl_now && prev_sda && !sda_now) begin
                n_start++;
                in_txn = 1'b1;
                falls  = 0;
                bit_n  = 0;
                word   = 0;
            end else if (prev_scl && scl_now && !prev_sda && sda_now) begin
                n_stop++;
                // last SCL rise belongs to the stop condition, not to a data bit
                if (in_txn) mon_q.push_back('{bit_n - 1, word >> 1});
                in_txn = 1'b0;
            end
            if (in_txn && prev_scl && !scl_now) begin
                falls++;
                slave_low = ((falls == 9) && rsp_ack_addr) || ((falls == 18) && rsp_ack_data);
            end
            if (in_txn && !prev_scl && scl_now) begin
                bit_n++;
                word = word * 2 + int'(sda_now);
            end
            prev_scl = scl_now;
            prev_sda = sda_now;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_near(input string name, input int act, input int exp, input int tol);
        n_chk++;
        if (act < exp - tol || act > exp + tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp, tol);
        end
    endtask

    // expected bus bit stream: address byte with W=0, ack, then data and ack if addressed
    function automatic int bus_word(input tvec_t v);
        int w;
        w = int'(v.addr) * 2;
        w = w * 2 + (v.aa ? 0 : 1);
        if (v.aa) begin
            w = w * 256 + int'(v.data);
            w = w * 2 + (v.ad ? 0 : 1);
        end
        return w;
    endfunction

    function automatic tvec_t mk(input logic [6:0] a, input logic [7:0] d,
                                 input bit aa, input bit ad, input bit intf);
        tvec_t v;
        v.addr      = a;
        v.data      = d;
        v.aa        = aa;
        v.ad        = ad;
        v.intf      = intf;
        v.exp_err   = (!aa || !ad) ? 1 : 0;
        v.exp_nbits = aa ? 18 : 9;
        v.exp_lat   = (aa ? 20 : 11) * 4 * CD;
        return v;
    endfunction

    task automatic wait_done(input int budget, input bit intf, output int lat);
        int cyc;
        cyc = 0;
        lat = -1;
        while (cyc < budget && lat < 0) begin
            @(negedge clk);
            cyc++;
            if (cyc == 2) check("busy_active", busy, 1);
            if (done) begin
                lat = cyc - 1;
            end else if (intf && cyc == 50) begin
                start = 1'b1;
                addr  = 7'($urandom);
                data  = 8'($urandom);
            end else if (intf && cyc == 51) begin
                start = 1'b0;
            end
        end
        if (lat < 0) check("done_timeout", 0, 1);
    endtask

    task automatic check_record(input tvec_t v);
        rec_t r;
        check("bus_record_count", mon_q.size() - rd_idx, 1);
        if (mon_q.size() > rd_idx) begin
            r = mon_q[rd_idx];
            check("bus_bits", r.n, v.exp_nbits);
            check("bus_word", r.word, bus_word(v));
        end
        rd_idx = mon_q.size();
    endtask

    task automatic run_txn(input tvec_t v);
        int lat;
        rsp_ack_addr = v.aa;
        rsp_ack_data = v.ad;
        @(negedge clk);
        addr  = v.addr;
        data  = v.data;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        addr  = 7'($urandom);
        data  = 8'($urandom);
        wait_done(200 * CD, v.intf, lat);
        if (lat >= 0) begin
            check_near("latency", lat, v.exp_lat, 1);
            check("done_busy_low", busy, 0);
            check("ack_error", ack_error, v.exp_err);
            @(negedge clk);
            check("done_width", done, 0);
            check("ack_error_hold", ack_error, v.exp_err);
        end
        check_record(v);
    endtask

    initial begin
        tvec_t tbl[6];
        tvec_t v;
        int    lat;
        int    cyc;

        tbl[0] = '{7'h2A, 8'hA5, 1'b1, 1'b1, 1'b0, 0, 18, 320};
        tbl[1] = '{7'h2B, 8'h3C, 1'b0, 1'b1, 1'b0, 1,  9, 176};
        tbl[2] = '{7'h2A, 8'hA5, 1'b1, 1'b0, 1'b0, 1, 18, 320};
        tbl[3] = '{7'h2A, 8'hA5, 1'b1, 1'b1, 1'b1, 0, 18, 320};
        tbl[4] = '{7'h7F, 8'h00, 1'b1, 1'b1, 1'b0, 0, 18, 320};
        tbl[5] = '{7'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 1,  9, 176};

        repeat (3) @(negedge clk);
        check("rst_scl", i2c_scl, 1);
        check("rst_sda", i2c_sda, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ack_error", ack_error, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_scl", i2c_scl, 1);
        check("idle_busy", busy, 0);

        for (int i = 0; i < 6; i++) run_txn(tbl[i]);

        // abort during data bit 3 while SCL is low
        rsp_ack_addr = 1'b1;
        rsp_ack_data = 1'b1;
        @(negedge clk);
        addr  = 7'h2A;
        data  = 8'hA5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        while (falls != 14 && cyc < 200 * CD) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_reached_bit3", falls, 14);
        rst = 1'b1;
        #1;
        check("abort_scl", i2c_scl, 1);
        check("abort_sda", i2c_sda, 1);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("abort_no_record", mon_q.size() - rd_idx, 0);
        run_txn(mk(7'h2A, 8'hA5, 1'b1, 1'b1, 1'b0));

        // start held high: second transaction follows immediately after DONE
        v = mk(7'h15, 8'h5A, 1'b1, 1'b1, 1'b0);
        rsp_ack_addr = 1'b1;
        rsp_ack_data = 1'b1;
        @(negedge clk);
        addr  = v.addr;
        data  = v.data;
        start = 1'b1;
        wait_done(200 * CD, 1'b0, lat);
        check_near("held_latency", lat, v.exp_lat, 1);
        @(negedge clk);
        check("held_idle_gap", busy, 0);
        @(negedge clk);
        check("held_restart_busy", busy, 1);
        start = 1'b0;
        wait_done(200 * CD, 1'b0, lat);
        check("held_records", mon_q.size() - rd_idx, 2);
        if (mon_q.size() >= rd_idx + 2) begin
            check("held_word0", mon_q[rd_idx].word, bus_word(v));
            check("held_word1", mon_q[rd_idx + 1].word, bus_word(v));
        end
        rd_idx = mon_q.size();
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_txn(mk(7'($urandom), 8'($urandom), $urandom_range(0, 3) != 0,
                       $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0));
        end

        repeat (5) @(negedge clk);
        check("total_done_pulses", n_done, 21);
        check("total_start_conditions", n_start, 22);
        check("total_stop_conditions", n_stop, 21);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/i2c_write_controller.md
I2C_WRITE_CONTROLLER -- requirements
Module: i2c_write_controller

Interface
REQ-001 Parameter: CLK_DIV, default 4, number of clk cycles per quarter SCL bit-period (legal range 2..255).
REQ-002 Port: clk  input  1  system clock; all logic on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: start  input  1  request to begin one write transaction; sampled only in IDLE.
REQ-005 Port: addr  input  7  target 7-bit address; captured on accepted start.
REQ-006 Port: data  input  8  byte to write; captured on accepted start.
REQ-007 Port: busy  output  1  high from the cycle after start is accepted until the transaction completes.
REQ-008 Port: done  output  1  one-clk pulse at transaction end.
REQ-009 Port: ack_error  output  1  high when the last transaction saw a NACK; valid from done until the next accepted start.
REQ-010 Port: i2c_scl  output  1  bus clock, driven push-pull, idle high.
REQ-011 Port: i2c_sda  inout  1  bus data, open-drain: driven 0 or released to high-Z, never driven 1.

Function
REQ-012 Quarter tick: a counter runs 0..CLK_DIV-1 while busy and pulses tick for one clk at CLK_DIV-1; it is held at 0 in IDLE.
REQ-013 Each bit slot is 4 ticks (Q0..Q3): SCL low in Q0-Q1, high in Q2-Q3; SDA changes only at entry to Q0.
REQ-014 States: IDLE, START, ADDR, ACK1, DATA, ACK2, STOP, DONE.
REQ-015 IDLE: SCL high, SDA released, busy 0; start=1 latches addr, data, clears ack_error, goes to START next clk.
REQ-016 START: SDA released with SCL high for 2 ticks, then SDA driven low for 2 ticks with SCL high (start condition), then goes to ADDR.
REQ-017 ADDR: shifts 8 bits MSB first, {addr[6:0], 1'b0} (R/W = 0, write), one bit per slot; then goes to ACK1.
REQ-018 ACK1: SDA released for one slot; SDA sampled on the tick ending Q2; 0 -> DATA; 1 -> ack_error=1, go to STOP.
REQ-019 DATA: shifts data[7:0] MSB first, one bit per slot; then goes to ACK2.
REQ-020 ACK2: as ACK1; 1 sets ack_error; both outcomes go to STOP.
REQ-021 STOP: SDA driven low with SCL low for 1 tick, SCL high for 1 tick, then SDA released with SCL high for 2 ticks (stop condition); then goes to DONE.
REQ-022 DONE: done=1 for exactly one clk, busy=0 the same clk, then IDLE.
REQ-023 start asserted while busy is ignored; start held high continuously starts a new transaction on the first clk after DONE.
REQ-024 addr/data changes during a transaction have no effect.
REQ-025 Bit counter is 3 bits and counts 7 down to 0; ADDR->ACK1 and DATA->ACK2 transitions occur on the tick ending Q3 of count 0.
REQ-026 A full ACKed transaction takes exactly (1+9+9+1)*4 ticks = 80*CLK_DIV clk from accepted start to done, +/-1 clk for the IDLE->START and DONE cycles.
REQ-027 SDA never changes while SCL is high except for the start and stop conditions.

Reset
REQ-028 rst=1 immediately forces: state IDLE, counters 0, i2c_scl=1, i2c_sda released, busy=0, done=0, ack_error=0.
REQ-029 rst asserted mid-transaction aborts it with no stop condition generated; after release the block is in IDLE and accepts a new start.

Verification
REQ-030 CLK_DIV=4, addr=7'h2A, data=8'hA5, responder ACKs both -> SDA bits 0x54 then 0xA5 at SCL rising edges; ack_error=0; done pulses once at 320+/-1 clk.
REQ-031 addr=7'h2B, no responder (SDA pulled high) -> ack_error=1 after ACK1; no DATA bits clocked; stop condition seen; done pulses.
REQ-032 addr=7'h2A ACKed, data byte NACKed -> ack_error=1; stop condition seen; done pulses.
REQ-033 start pulsed again at cycle 50 of a transaction, addr/data changed -> ignored; bus bytes unchanged; single done.
REQ-034 rst asserted during DATA bit 3 -> same clk SCL=1, SDA high-Z, busy=0; next start produces a clean full transaction.
REQ-035 Bus monitor throughout all scenarios -> SDA transitions while SCL high only at start and stop conditions; SDA never driven 1.
